// File: rtl/rnd_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : rnd_seg_display
// Purpose  : Takes the 8-bit value from the upstream LFSR generator, turns each
//            new value into three BCD digits with a bit-serial double-dabble
//            converter, and drives a multiplexed 3-digit active-low 7-segment
//            display. Leading zeros are blanked.
// Ports    : clock_i   - system clock, rising edge
//            reset_ni  - asynchronous active-low reset
//            rnd_i     - random byte from the generator
//            seg_o     - segments {g,f,e,d,c,b,a}, active-low, registered
//            an_o      - digit enables, active-low one-hot (0=ones,1=tens,2=hundreds)
//            upd_o     - one-cycle pulse when new BCD digits are latched
// Revision : 1.0 - initial release
// ============================================================================
module rnd_seg_display #(
   parameter int REFRESH_DIV = 50000   // clock cycles per digit slot, >= 2
) (
   input  logic       clock_i,
   input  logic       reset_ni,
   input  logic [7:0] rnd_i,
   output logic [6:0] seg_o,
   output logic [2:0] an_o,
   output logic       upd_o
);

   localparam int                DIV_W    = $clog2(REFRESH_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [7:0]       rnd_s_q;
   logic [7:0]       last_q, last_d;
   logic [19:0]      sh_q, sh_d;
   logic [19:0]      sh_adj;
   logic [2:0]       cnt_q, cnt_d;
   logic [11:0]      bcd_q, bcd_d;
   logic             upd_q, upd_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic [6:0]       seg_q, seg_d;
   logic [2:0]       an_q, an_d;
   logic [3:0]       nib;
   logic             blank;

   function automatic logic [6:0] seg_enc(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift
   // so that it carries correctly into the next decimal digit.
   always_comb begin
      sh_adj = sh_q;
      if (sh_q[11:8]  >= 4'd5) sh_adj[11:8]  = sh_q[11:8]  + 4'd3;
      if (sh_q[15:12] >= 4'd5) sh_adj[15:12] = sh_q[15:12] + 4'd3;
      if (sh_q[19:16] >= 4'd5) sh_adj[19:16] = sh_q[19:16] + 4'd3;
   end

   // Conversion FSM next-state logic
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      upd_d   = 1'b0;
      case (state_q)
         IDLE: begin
            // A value that changed during a previous conversion still differs
            // from last_q here, so it is picked up without being lost.
            if (rnd_s_q != last_q) begin
               sh_d    = {12'b0, rnd_s_q};
               last_d  = rnd_s_q;
               cnt_d   = 3'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sh_d  = {sh_adj[18:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bcd_d   = sh_q[19:8];
            upd_d   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Scan timing and digit selection. an/seg are derived from idx_d so the
   // digit change and the new enable/segment pattern appear on the same edge.
   always_comb begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
      if (div_q == DIV_LAST) begin
         div_d = '0;
         idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end

      case (idx_d)
         2'd0: begin
            an_d  = 3'b110;
            nib   = bcd_q[3:0];
            blank = 1'b0;
         end
         2'd1: begin
            an_d  = 3'b101;
            nib   = bcd_q[7:4];
            blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
         end
         2'd2: begin
            an_d  = 3'b011;
            nib   = bcd_q[11:8];
            blank = (bcd_q[11:8] == 4'd0);
         end
         default: begin
            an_d  = 3'b111;
            nib   = 4'd0;
            blank = 1'b1;
         end
      endcase

      seg_d = blank ? 7'h7F : seg_enc(nib);
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         rnd_s_q <= 8'd0;
         last_q  <= 8'd0;
         sh_q    <= 20'd0;
         cnt_q   <= 3'd0;
         bcd_q   <= 12'd0;
         upd_q   <= 1'b0;
         div_q   <= '0;
         idx_q   <= 2'd0;
         seg_q   <= 7'h7F;
         an_q    <= 3'b111;
      end else begin
         state_q <= state_d;
         rnd_s_q <= rnd_i;
         last_q  <= last_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         upd_q   <= upd_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign seg_o = seg_q;
   assign an_o  = an_q;
   assign upd_o = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_rnd_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_rnd_seg_display
// Purpose  : Directed self-checking bench for rnd_seg_display with a short
//            refresh divider so whole display frames fit in a few cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rnd_seg_display;

   localparam int RD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] rnd = 8'd0;
   logic [6:0] seg_o;
   logic [2:0] an_o;
   logic       upd_o;

   int checks   = 0;
   int failures = 0;

   rnd_seg_display #(.REFRESH_DIV(RD)) dut (
      .clock_i  (clk),
      .reset_ni (rst_n),
      .rnd_i    (rnd),
      .seg_o    (seg_o),
      .an_o     (an_o),
      .upd_o    (upd_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts rising edges until upd_o is seen high (sampled 1 time unit after
   // each edge). Returns 40 if it never appears.
   task automatic wait_upd(output int edges);
      edges = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         edges++;
         if (upd_o) break;
      end
   endtask

   task automatic set_rnd(input logic [7:0] v);
      @(negedge clk);
      rnd = v;
   endtask

   // Waits (bounded) for the given digit to be enabled, then checks segments.
   task automatic scan_digit(input string tag, input logic [2:0] an_exp, input logic [6:0] seg_exp);
      for (int i = 0; i < 3*RD + 2; i++) begin
         if (an_o == an_exp) break;
         @(posedge clk); #1;
      end
      check_eq({tag, "_an"}, {29'd0, an_o}, {29'd0, an_exp});
      check_eq({tag, "_seg"}, {25'd0, seg_o}, {25'd0, seg_exp});
   endtask

   task automatic convert(input string tag, input logic [7:0] v, input logic [11:0] bcd_exp);
      int e;
      set_rnd(v);
      wait_upd(e);
      check_eq({tag, "_latency"}, e, 11);
      check_eq({tag, "_bcd"}, {20'd0, dut.bcd_q}, {20'd0, bcd_exp});
      @(posedge clk); #1;
   endtask

   initial begin
      int e;
      int seen;

      // Reset asserted asynchronously
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_seg", {25'd0, seg_o}, 32'h7F);
      check_eq("rst_an",  {29'd0, an_o},  32'h7);
      check_eq("rst_upd", {31'd0, upd_o}, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rel_an",  {29'd0, an_o},  32'h6);
      check_eq("rel_seg", {25'd0, seg_o}, 32'h40);

      // rnd = 0 matches last after reset: nothing to convert
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (upd_o) seen++;
      end
      check_eq("zero_no_upd", seen, 0);

      // 13
      convert("r13", 8'd13, 12'h013);
      check_eq("r13_upd_pulse", {31'd0, upd_o}, 32'h0);
      scan_digit("r13_ones", 3'b110, 7'h30);
      scan_digit("r13_tens", 3'b101, 7'h79);
      scan_digit("r13_hund", 3'b011, 7'h7F);

      // 255
      convert("r255", 8'd255, 12'h255);
      scan_digit("r255_ones", 3'b110, 7'h12);
      scan_digit("r255_tens", 3'b101, 7'h12);
      scan_digit("r255_hund", 3'b011, 7'h24);

      // 100: inner zero must stay visible
      convert("r100", 8'd100, 12'h100);
      scan_digit("r100_ones", 3'b110, 7'h40);
      scan_digit("r100_tens", 3'b101, 7'h40);
      scan_digit("r100_hund", 3'b011, 7'h79);

      // 5: both leading digits blanked
      convert("r5", 8'd5, 12'h005);
      scan_digit("r5_ones", 3'b110, 7'h12);
      scan_digit("r5_tens", 3'b101, 7'h7F);
      scan_digit("r5_hund", 3'b011, 7'h7F);

      // 13 -> 200 while the 13 conversion is shifting
      set_rnd(8'd13);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rnd = 8'd200;
      wait_upd(e);
      check_eq("chg_first_lat", e, 6);
      check_eq("chg_first_bcd", {20'd0, dut.bcd_q}, 32'h013);
      wait_upd(e);
      check_eq("chg_second_lat", e, 10);
      check_eq("chg_second_bcd", {20'd0, dut.bcd_q}, 32'h200);
      @(posedge clk); #1;
      scan_digit("r200_ones", 3'b110, 7'h40);
      scan_digit("r200_tens", 3'b101, 7'h40);
      scan_digit("r200_hund", 3'b011, 7'h24);

      // Reset in the middle of converting 77
      set_rnd(8'd77);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_seg", {25'd0, seg_o}, 32'h7F);
      check_eq("mid_rst_an",  {29'd0, an_o},  32'h7);
      check_eq("mid_rst_upd", {31'd0, upd_o}, 32'h0);
      check_eq("mid_rst_bcd", {20'd0, dut.bcd_q}, 32'h0);
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (upd_o) seen++;
      end
      check_eq("mid_rst_no_upd", seen, 0);
      check_eq("mid_rst_bcd_hold", {20'd0, dut.bcd_q}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_upd(e);
      check_eq("r77_latency", e, 11);
      check_eq("r77_bcd", {20'd0, dut.bcd_q}, 32'h077);
      @(posedge clk); #1;
      scan_digit("r77_ones", 3'b110, 7'h78);
      scan_digit("r77_tens", 3'b101, 7'h78);
      scan_digit("r77_hund", 3'b011, 7'h7F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
